fir_pe_param: RTL and testbench

FIR_PE_PARAM -- requirements
Module: fir_pe_param

---
 rtl/fir_pe_if.sv | 30 +++
 rtl/fir_pe_param.sv | 172 +++++++++++++++++
 tb/tb_fir_pe_param.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fir_pe_if.sv
// fir_pe_if -- handshake and digit-stream bundle for one FIR processing element.
//   master : frame/coefficient driver (Rdy, Cld, Cin, Xin, Yin out; results in)
//   slave  : the processing element (Xout, Yout, Vld, Busy, Sat, Err out)
//   DW : digit width, CW : coefficient width
interface fir_pe_if #(
    parameter int DW = 4,
    parameter int CW = 6
);
    logic          Rdy;
    logic          Cld;
    logic [CW-1:0] Cin;
    logic [DW-1:0] Xin;
    logic [DW-1:0] Yin;
    logic [DW-1:0] Xout;
    logic [DW-1:0] Yout;
    logic          Vld;
    logic          Busy;
    logic          Sat;
    logic          Err;

    modport master (
        output Rdy, Cld, Cin, Xin, Yin,
        input  Xout, Yout, Vld, Busy, Sat, Err
    );

    modport slave (
        input  Rdy, Cld, Cin, Xin, Yin,
        output Xout, Yout, Vld, Busy, Sat, Err
    );
endinterface

// File: rtl/fir_pe_param.sv
// fir_pe_param -- digit-serial multiply-accumulate element for a systolic FIR chain.
// Each frame shifts in YD partial-sum digits (Yin) and XD operand digits (Xin),
// LSD first, computes R = Y + X*C with optional saturation, and streams the
// previous frame's R and X out (Yout/Xout) while the new frame loads.
//   clk, rst : clock, synchronous active-high reset
//   bus      : fir_pe_if slave (Rdy, Cld, Cin, Xin, Yin -> Xout, Yout, Vld, Busy, Sat, Err)
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for Rdy
// LOAD  | capturing Yin/Xin digits, streaming previous Rreg/Xreg out
// MAC   | one-cycle multiply-accumulate into Rreg, overflow into Sat
// DONE  | result valid (Vld); Rdy here starts the next frame directly
module fir_pe_param #(
    parameter int DW  = 4,
    parameter int XD  = 2,
    parameter int YD  = 4,
    parameter int CW  = 6,
    parameter int SAT = 1
) (
    input logic      clk,
    input logic      rst,
    fir_pe_if.slave  bus
);
    localparam int AW   = YD * DW;
    localparam int XW   = XD * DW;
    localparam int PW   = XW + CW;
    localparam int SW   = AW + 1;
    localparam int CNTW = (YD > 1) ? $clog2(YD) : 1;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(YD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [XW-1:0]   xreg_q, xreg_d;
    logic [AW-1:0]   yreg_q, yreg_d;
    logic [AW-1:0]   rreg_q, rreg_d;
    logic [CW-1:0]   creg_q, creg_d;
    logic            sat_q, sat_d;
    logic            err_q, err_d;

    logic [PW-1:0]   prod;
    logic [SW-1:0]   sum_full;
    logic [DW-1:0]   xout_c;
    logic [DW-1:0]   yout_c;

    // Product always fits in AW bits, so the AW+1 bit sum carries at most one overflow bit.
    always_comb begin
        prod     = PW'(xreg_q) * PW'(creg_q);
        sum_full = {1'b0, yreg_q} + SW'(prod);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        xreg_d  = xreg_q;
        yreg_d  = yreg_q;
        rreg_d  = rreg_q;
        creg_d  = creg_q;
        sat_d   = sat_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.Rdy) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                if (bus.Rdy) begin
                    err_d = 1'b1;
                end
                for (int i = 0; i < YD; i++) begin
                    if (cnt_q == CNTW'(i)) begin
                        yreg_d[i*DW +: DW] = bus.Yin;
                    end
                end
                for (int i = 0; i < XD; i++) begin
                    if (cnt_q == CNTW'(i)) begin
                        xreg_d[i*DW +: DW] = bus.Xin;
                    end
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = MAC;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            MAC: begin
                if (bus.Rdy) begin
                    err_d = 1'b1;
                end
                if (sum_full[AW]) begin
                    sat_d  = 1'b1;
                    rreg_d = (SAT != 0) ? {AW{1'b1}} : sum_full[AW-1:0];
                end else begin
                    sat_d  = 1'b0;
                    rreg_d = sum_full[AW-1:0];
                end
                state_d = DONE;
            end
            DONE: begin
                cnt_d   = '0;
                state_d = bus.Rdy ? LOAD : IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Coefficient loads in any state; the MAC above already used the old value.
        if (bus.Cld) begin
            creg_d = bus.Cin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            xreg_q  <= '0;
            yreg_q  <= '0;
            rreg_q  <= '0;
            creg_q  <= '0;
            sat_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            xreg_q  <= xreg_d;
            yreg_q  <= yreg_d;
            rreg_q  <= rreg_d;
            creg_q  <= creg_d;
            sat_q   <= sat_d;
            err_q   <= err_d;
        end
    end

    // Digit k of the previous result/operand goes out in the same cycle that
    // digit k of the new frame is captured, so nothing is lost before overwrite.
    always_comb begin
        xout_c = '0;
        yout_c = '0;
        if (state_q == LOAD) begin
            for (int i = 0; i < YD; i++) begin
                if (cnt_q == CNTW'(i)) begin
                    yout_c = rreg_q[i*DW +: DW];
                end
            end
            for (int i = 0; i < XD; i++) begin
                if (cnt_q == CNTW'(i)) begin
                    xout_c = xreg_q[i*DW +: DW];
                end
            end
        end
    end

    assign bus.Xout = xout_c;
    assign bus.Yout = yout_c;
    assign bus.Vld  = (state_q == DONE);
    assign bus.Busy = (state_q == LOAD) || (state_q == MAC);
    assign bus.Sat  = sat_q;
    assign bus.Err  = err_q;

endmodule

// File: tb/tb_fir_pe_param.sv
// Scoreboard bench for fir_pe_param: a saturating and a wrapping instance run
// in lockstep; stimulus pushes expected Vld timing/Sat and expected output
// streams, a monitor pops and compares.
module tb_fir_pe_param;
    localparam int DW = 4;
    localparam int XD = 2;
    localparam int YD = 4;
    localparam int CW = 6;
    localparam int AW = YD * DW;

    logic clk;
    logic rst;
    int   cyc;
    int   n_cmp;
    int   n_bad;
    bit   mon_en;

    fir_pe_if #(.DW(DW), .CW(CW)) bus1 ();
    fir_pe_if #(.DW(DW), .CW(CW)) bus0 ();

    fir_pe_param #(.DW(DW), .XD(XD), .YD(YD), .CW(CW), .SAT(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    fir_pe_param #(.DW(DW), .XD(XD), .YD(YD), .CW(CW), .SAT(0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    assign bus0.Rdy = bus1.Rdy;
    assign bus0.Cld = bus1.Cld;
    assign bus0.Cin = bus1.Cin;
    assign bus0.Xin = bus1.Xin;
    assign bus0.Yin = bus1.Yin;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [AW-1:0] y1;
        logic [AW-1:0] y0;
        logic [AW-1:0] x;
    } strm_t;

    typedef struct {
        int   cyc;
        logic sat;
    } vld_t;

    strm_t sq[$];
    vld_t  vq[$];

    logic [AW-1:0] prev_r1, prev_r0, prev_x;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus1.Rdy = 1'b0;
        bus1.Cld = 1'b0;
        bus1.Xin = '0;
        bus1.Yin = '0;
        repeat (n) tick();
    endtask

    task automatic load_coef(input logic [CW-1:0] c);
        bus1.Cld = 1'b1;
        bus1.Cin = c;
        tick();
        bus1.Cld = 1'b0;
    endtask

    // Returns at the start of the DONE cycle so the caller can chain frames.
    task automatic run_frame(input logic [AW-1:0] x, input logic [AW-1:0] y,
                             input logic [AW-1:0] r1, input logic [AW-1:0] r0,
                             input logic s, input bit cld0, input logic [CW-1:0] c0,
                             input bit err_rdy, input bit cld_mac, input logic [CW-1:0] cm);
        strm_t st;
        vld_t  vt;
        st.y1 = prev_r1;
        st.y0 = prev_r0;
        st.x  = prev_x;
        sq.push_back(st);
        vt.cyc = cyc + YD + 2;
        vt.sat = s;
        vq.push_back(vt);
        bus1.Rdy = 1'b1;
        bus1.Cld = cld0;
        bus1.Cin = c0;
        tick();
        bus1.Cld = 1'b0;
        for (int k = 1; k <= YD; k++) begin
            bus1.Rdy = err_rdy && (k == 2);
            bus1.Yin = y[(k-1)*DW +: DW];
            bus1.Xin = (k <= XD) ? x[(k-1)*DW +: DW] : {DW{1'b1}};
            tick();
        end
        bus1.Rdy = 1'b0;
        bus1.Xin = '0;
        bus1.Yin = '0;
        bus1.Cld = cld_mac;
        bus1.Cin = cm;
        tick();
        bus1.Cld = 1'b0;
        prev_r1 = r1;
        prev_r0 = r0;
        prev_x  = x;
    endtask

    // Monitor: Vld timing and Sat, then the streamed previous result/operand.
    initial begin
        int idx;
        logic [AW-1:0] ya1, ya0, xa1, xa0;
        strm_t st;
        vld_t  vt;
        idx = 0;
        ya1 = '0; ya0 = '0; xa1 = '0; xa0 = '0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                idx = 0;
                continue;
            end
            if (bus1.Vld || bus0.Vld) begin
                if (vq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL vld_unexpected: got Vld=%b/%b expected none (cycle %0d)",
                             bus1.Vld, bus0.Vld, cyc);
                end else begin
                    vt = vq.pop_front();
                    chk("vld_cycle", cyc, vt.cyc);
                    chk("vld_sat1", {31'd0, bus1.Vld}, 32'd1);
                    chk("vld_sat0", {31'd0, bus0.Vld}, 32'd1);
                    chk("sat_satmode", {31'd0, bus1.Sat}, {31'd0, vt.sat});
                    chk("sat_wrapmode", {31'd0, bus0.Sat}, {31'd0, vt.sat});
                end
            end
            if (bus1.Busy) begin
                if (idx < YD) begin
                    ya1[idx*DW +: DW] = bus1.Yout;
                    ya0[idx*DW +: DW] = bus0.Yout;
                    xa1[idx*DW +: DW] = bus1.Xout;
                    xa0[idx*DW +: DW] = bus0.Xout;
                end else begin
                    chk("mac_outs_zero", {24'd0, bus1.Xout, bus1.Yout}, 32'd0);
                end
                if (idx == YD - 1) begin
                    if (sq.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL stream_unexpected: got Yout=%h expected no frame (cycle %0d)",
                                 ya1, cyc);
                    end else begin
                        st = sq.pop_front();
                        chk("yout_satmode", {16'd0, ya1}, {16'd0, st.y1});
                        chk("yout_wrapmode", {16'd0, ya0}, {16'd0, st.y0});
                        chk("xout_satmode", {16'd0, xa1}, {16'd0, st.x});
                        chk("xout_wrapmode", {16'd0, xa0}, {16'd0, st.x});
                    end
                end
                idx++;
            end else begin
                idx = 0;
                chk("idle_outs_zero", {24'd0, bus1.Xout, bus1.Yout}, 32'd0);
            end
        end
    end

    initial begin
        int waited;
        n_cmp   = 0;
        n_bad   = 0;
        mon_en  = 1'b0;
        prev_r1 = '0;
        prev_r0 = '0;
        prev_x  = '0;
        rst      = 1'b1;
        bus1.Rdy = 1'b0;
        bus1.Cld = 1'b0;
        bus1.Cin = '0;
        bus1.Xin = '0;
        bus1.Yin = '0;
        repeat (3) tick();
        chk("rst_vld", {31'd0, bus1.Vld}, 32'd0);
        chk("rst_busy", {31'd0, bus1.Busy}, 32'd0);
        chk("rst_xout", {28'd0, bus1.Xout}, 32'd0);
        chk("rst_yout", {28'd0, bus1.Yout}, 32'd0);
        chk("rst_sat", {31'd0, bus1.Sat}, 32'd0);
        chk("rst_err", {31'd0, bus1.Err}, 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        idle(2);

        // Basic MAC: 0x1234 + 0x5A*0x2F = 0x22BA
        load_coef(6'h2F);
        run_frame(16'h005A, 16'h1234, 16'h22BA, 16'h22BA, 1'b0, 0, 6'h00, 0, 0, 6'h00);
        idle(2);

        // Overflow, coefficient loaded together with Rdy: 0xF000 + 0xFF*0x3F = 0x12EC1
        run_frame(16'h00FF, 16'hF000, 16'hFFFF, 16'h2EC1, 1'b1, 1, 6'h3F, 0, 0, 6'h00);
        idle(3);

        // Back-to-back frames, Creg = 0x3F
        run_frame(16'h0001, 16'h0001, 16'h0040, 16'h0040, 1'b0, 0, 6'h00, 0, 0, 6'h00);
        run_frame(16'h0010, 16'h0100, 16'h04F0, 16'h04F0, 1'b0, 0, 6'h00, 0, 0, 6'h00);
        run_frame(16'h00AB, 16'h1000, 16'h3A15, 16'h3A15, 1'b0, 0, 6'h00, 0, 0, 6'h00);
        chk("b2b_err", {31'd0, bus1.Err}, 32'd0);
        idle(2);

        // Protocol error: stray Rdy in cycle 2, result still 5 + 2*0x3F = 0x83
        run_frame(16'h0002, 16'h0005, 16'h0083, 16'h0083, 1'b0, 0, 6'h00, 1, 0, 6'h00);
        chk("err_set", {31'd0, bus1.Err}, 32'd1);
        idle(2);

        // Coefficient change in the MAC cycle applies from the next frame
        load_coef(6'd2);
        run_frame(16'h0003, 16'h0000, 16'h0006, 16'h0006, 1'b0, 0, 6'h00, 0, 1, 6'd1);
        idle(1);
        run_frame(16'h0003, 16'h0000, 16'h0003, 16'h0003, 1'b0, 0, 6'h00, 0, 0, 6'h00);
        chk("err_sticky", {31'd0, bus0.Err}, 32'd1);
        idle(2);

        // Reset in cycle 3 aborts the frame
        bus1.Rdy = 1'b1;
        tick();
        bus1.Rdy = 1'b0;
        bus1.Yin = 4'h1;
        bus1.Xin = 4'h7;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus1.Yin = '0;
        bus1.Xin = '0;
        chk("abort_busy", {31'd0, bus1.Busy}, 32'd0);
        chk("abort_vld", {31'd0, bus1.Vld}, 32'd0);
        chk("abort_err", {31'd0, bus1.Err}, 32'd0);
        chk("abort_sat", {31'd0, bus1.Sat}, 32'd0);
        prev_r1 = '0;
        prev_r0 = '0;
        prev_x  = '0;
        idle(2);
        run_frame(16'h0012, 16'h4321, 16'h4321, 16'h4321, 1'b0, 0, 6'h00, 0, 0, 6'h00);
        idle(1);
        run_frame(16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 0, 6'h00, 0, 0, 6'h00);
        idle(2);

        waited = 0;
        while ((sq.size() != 0 || vq.size() != 0) && waited < 50) begin
            tick();
            waited++;
        end
        if (sq.size() != 0 || vq.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d/%0d pending entries expected 0", sq.size(), vq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
